// File: rtl/core_pkg.sv
// core_pkg: shared core constants, fetch state encoding and counter sizing helper
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t START  = 3'd0;
  localparam fetch_state_t REQ    = 3'd1;
  localparam fetch_state_t HOLD   = 3'd2;
  localparam fetch_state_t SETTLE = 3'd3;
  localparam fetch_state_t HALTED = 3'd4;
  function automatic int cnt_width(input int max);
    return max > 0 ? $clog2(max + 1) : 1;
  endfunction
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: saturating wait counter whose done flags the increment that reaches MAX (MAX=0 never fires)
module fetch_timeout_counter import core_pkg::*; #(
  parameter int MAX = 255,
  localparam int W = cnt_width(MAX)
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic done
);
  logic [W-1:0] count;
  assign done = MAX != 0 && en && count == W'(MAX - 1);
  // count enabled wait cycles, holding at MAX; clear wins over enable
  always_ff @(posedge clk) begin
    if (Reset || clr) count <= '0;
    else if (en && count != W'(MAX)) count <= count + 1'b1;
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequences PC increment/load and the imem handshake, holding each fetched word for decode
module fetch_controller import core_pkg::*; #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [XLEN-1:0]      pc_value,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [XLEN-1:0]      pc_load_value,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic [31:0]          imem_rdata,
  output logic                 instr_valid,
  output logic [31:0]          instr,
  output logic [XLEN-1:0]      instr_pc,
  input  logic                 instr_ready,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_target,
  input  logic                 halt,
  output logic                 halted,
  output logic                 fetch_fault,
  output logic [CNT_WIDTH-1:0] fetch_count
);
  fetch_state_t state, state_nxt;
  logic redir, stop, take, tmo_done, tmo;
  assign redir = redirect_valid && state != HALTED;
  assign stop = !redir && halt && state != HALTED;
  assign take = state == REQ && imem_ready && !redir && !halt;
  assign tmo = tmo_done && !redir && !halt;
  assign pc_inc = !Reset && take;
  assign pc_load = !Reset && redir;
  assign pc_load_value = pc_load ? redirect_target : '0;
  assign imem_req = !Reset && state == REQ;
  assign imem_addr = pc_value;
  assign instr_valid = state == HOLD;
  assign halted = state == HALTED;
  fetch_timeout_counter #(.MAX(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .Reset(Reset),
    .clr(state != REQ || imem_ready || redir),
    .en(state == REQ && !imem_ready),
    .done(tmo_done)
  );
  // redirect beats halt beats the normal sequence; the PC strobes move the PC on this same edge
  always_comb begin
    state_nxt = redir ? SETTLE :
                stop ? HALTED :
                (state == START || state == SETTLE) ? REQ :
                take ? HOLD :
                tmo ? HALTED :
                (state == HOLD && instr_ready) ? REQ : state;
  end
  // state, held instruction, sticky fault and accepted-instruction count
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= START;
      instr <= '0;
      instr_pc <= '0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        instr <= imem_rdata;
        instr_pc <= pc_value;
      end
      if (tmo) fetch_fault <= 1'b1;
      if (state == HOLD && instr_ready) fetch_count <= fetch_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized fetch traffic against a rule-level model with a decoupled instruction scoreboard
module tb_fetch_controller;
  localparam int XL = 32;
  localparam int TMO = 8;
  localparam int CW = 32;
  typedef struct {logic [31:0] pc; logic [31:0] data;} item_t;
  logic clk = 0, Reset = 1;
  logic [XL-1:0] pc_value = '0, pc_load_value, imem_addr, instr_pc, redirect_target = '0;
  logic pc_inc, pc_load, imem_req, instr_valid, halted, fetch_fault;
  logic imem_ready = 0, instr_ready = 0, redirect_valid = 0, halt = 0;
  logic [31:0] imem_rdata = '0, instr;
  logic [CW-1:0] fetch_count;
  int checks = 0, errors = 0;
  item_t sb[$];
  bit m_halt, m_fault, m_hold, m_gap, armed;
  logic [31:0] m_pc, m_cnt;
  int m_wait, lat_left, hc;
  int p_ready, max_lat, p_redir, p_halt, p_never, p_rst;
  always #5 clk = ~clk;
  fetch_controller #(.XLEN(XL), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .Reset(Reset), .pc_value(pc_value), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt(halt),
    .halted(halted), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );
  // external PC register: clears on Reset, increment has priority over load
  always @(posedge clk) begin
    if (Reset) pc_value <= '0;
    else if (pc_inc) pc_value <= pc_value + 1;
    else if (pc_load) pc_value <= pc_load_value;
  end
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_halt = 0; m_fault = 0; m_hold = 0; m_gap = 1; armed = 0;
    m_pc = 0; m_cnt = 0; m_wait = 0;
    sb.delete();
  endtask
  task automatic cycle(input bit rst);
    bit req, rdy, ir, rv, hl, acc, exp_inc, exp_load;
    logic [31:0] tgt;
    @(negedge clk);
    req = !m_halt && !m_hold && !m_gap;
    chk("imem_req", imem_req, req);
    if (req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_hold);
    chk("halted", halted, m_halt);
    chk("fetch_fault", fetch_fault, m_fault);
    chk("fetch_count", fetch_count, m_cnt);
    if (req && !armed) begin
      armed = 1;
      lat_left = ($urandom_range(0, 99) < p_never) ? 1000 : $urandom_range(0, max_lat);
    end
    rdy = req && armed && lat_left == 0;
    if (req && lat_left > 0) lat_left--;
    ir = $urandom_range(0, 99) < p_ready;
    rv = $urandom_range(0, 99) < p_redir;
    hl = $urandom_range(0, 99) < p_halt;
    tgt = $urandom_range(0, 255);
    Reset = rst;
    imem_ready = rdy || (!req && $urandom_range(0, 3) == 0);
    imem_rdata = rdy ? mem(m_pc) : $urandom;
    instr_ready = ir;
    redirect_valid = rv;
    redirect_target = tgt;
    halt = hl;
    #1;
    exp_load = !rst && rv && !m_halt;
    exp_inc = !rst && !exp_load && !hl && rdy;
    chk("pc_inc", pc_inc, exp_inc);
    chk("pc_load", pc_load, exp_load);
    if (exp_load) chk("pc_load_value", pc_load_value, tgt);
    if (rst) model_reset();
    else begin
      acc = m_hold && ir;
      if (acc) m_cnt++;
      if (rv && !m_halt) begin
        if (m_hold && !ir) void'(sb.pop_front());
        m_pc = tgt; m_hold = 0; m_gap = 1; m_wait = 0; armed = 0;
      end else if (hl && !m_halt) begin
        if (m_hold && !ir) void'(sb.pop_front());
        m_halt = 1; m_hold = 0; m_gap = 0; armed = 0;
      end else if (m_gap) m_gap = 0;
      else if (req) begin
        if (rdy) begin
          sb.push_back('{pc: m_pc, data: mem(m_pc)});
          m_pc++; m_hold = 1; m_wait = 0; armed = 0;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_halt = 1; m_fault = 1; armed = 0;
          end
        end
      end else if (acc) m_hold = 0;
    end
  endtask
  task automatic phase(input int n, input int pr, input int ml, input int prd, input int ph, input int pn, input int prs);
    p_ready = pr; max_lat = ml; p_redir = prd; p_halt = ph; p_never = pn; p_rst = prs;
    cycle(1);
    hc = 0;
    for (int i = 0; i < n; i++) begin
      hc = m_halt ? hc + 1 : 0;
      cycle(($urandom_range(0, 999) < p_rst) || hc >= 12);
    end
  endtask
  // scoreboard monitor: every decode acceptance must deliver the oldest outstanding fetch
  always @(negedge clk) begin
    item_t e;
    #2;
    if (!Reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: accepted instr %0h pc %0h with no fetch expected", instr, instr_pc);
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.data);
        chk("instr_pc", instr_pc, e.pc);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    model_reset();
    phase(30, 100, 0, 0, 0, 0, 0);
    phase(80, 100, 3, 0, 0, 0, 0);
    phase(200, 30, 2, 0, 0, 0, 0);
    phase(400, 60, 3, 8, 0, 0, 0);
    phase(150, 80, 2, 0, 0, 25, 0);
    phase(200, 50, 2, 10, 3, 0, 0);
    phase(1500, 60, 4, 5, 2, 3, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
